// File: rtl/add_result_buffer.sv
// rtl/add_result_buffer.sv - 2-entry skid buffer for adder results with sticky overflow and result count
// Optional feature macro: RESULT_SAT_EN (saturate stored sum on overflow)
module add_result_buffer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             carry_i,
    input  logic             overflow_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    input  logic             clear_i,
    output logic             sticky_ovf_o,
    output logic [CNT_W-1:0] result_count_o
);

    localparam int PW = WIDTH + 2;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW-1:0]    w_in;
    logic [WIDTH-1:0] w_sum_store;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_count;
    logic             r_sticky;

`ifdef RESULT_SAT_EN
    // Clamp an overflowed sum to the extreme of the sign it should have had
    always_comb begin
        w_sum_store = sum_i;
        if (overflow_i) begin
            w_sum_store = sum_i[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                         : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign w_sum_store = sum_i;
`endif

    // Entry layout: {sum, carry, overflow}
    assign w_in   = {w_sum_store, carry_i, overflow_i};
    assign w_push = valid_i & ready_o;
    assign w_pop  = valid_o & ready_i;

    // Occupancy state register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // Occupancy next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_push) w_state_nxt = S_ONE;
            S_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = S_FULL;
                else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_pop) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Handshake outputs decoded only from the state register
    always_comb begin
        ready_o = 1'b1;
        valid_o = 1'b0;
        case (r_state)
            S_EMPTY: begin ready_o = 1'b1; valid_o = 1'b0; end
            S_ONE:   begin ready_o = 1'b1; valid_o = 1'b1; end
            S_FULL:  begin ready_o = 1'b0; valid_o = 1'b1; end
            default: begin ready_o = 1'b1; valid_o = 1'b0; end
        endcase
    end

    // Entry storage; head is the output register and keeps its value when drained
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) r_head <= w_in;
                S_ONE: begin
                    if (w_push && w_pop) r_head <= w_in;
                    else if (w_push)     r_tail <= w_in;
                end
                S_FULL:  if (w_pop) r_head <= r_tail;
                default: ;
            endcase
        end
    end

    // Status: push takes priority over a simultaneous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count  <= '0;
            r_sticky <= 1'b0;
        end else if (w_push) begin
            r_count  <= clear_i ? {{(CNT_W-1){1'b0}}, 1'b1} : r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            r_sticky <= clear_i ? overflow_i : (r_sticky | overflow_i);
        end else if (clear_i) begin
            r_count  <= '0;
            r_sticky <= 1'b0;
        end
    end

    assign sum_o          = r_head[PW-1:2];
    assign carry_o        = r_head[1];
    assign overflow_o     = r_head[0];
    assign sticky_ovf_o   = r_sticky;
    assign result_count_o = r_count;

endmodule

// File: tb/tb_add_result_buffer.sv
// tb/tb_add_result_buffer.sv - table-driven scoreboard bench for add_result_buffer
module tb_add_result_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] sum_i;
    logic        carry_i;
    logic        overflow_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] sum_o;
    logic        carry_o;
    logic        overflow_o;
    logic        clear_i;
    logic        sticky_ovf_o;
    logic [15:0] result_count_o;

    always #5 clk = ~clk;

    add_result_buffer #(.WIDTH(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .valid_i(valid_i), .ready_o(ready_o),
        .sum_i(sum_i), .carry_i(carry_i), .overflow_i(overflow_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .sum_o(sum_o), .carry_o(carry_o), .overflow_o(overflow_o),
        .clear_i(clear_i), .sticky_ovf_o(sticky_ovf_o), .result_count_o(result_count_o)
    );

    typedef struct {
        bit          v;
        logic [31:0] s;
        bit          c;
        bit          o;
        bit          r;
        bit          clr;
        int          exp_cnt;   // -1 = no explicit check
        int          exp_stk;   // -1 = no explicit check
    } vec_t;

    vec_t        vecs[$];
    logic [33:0] sb[$];
    int          occ;
    int unsigned m_cnt;
    bit          m_stk;
    int          tests;
    int          fails;

    function automatic vec_t mk(bit v, logic [31:0] s, bit c, bit o, bit r, bit clr,
                                int ec, int es);
        vec_t x;
        x.v = v; x.s = s; x.c = c; x.o = o; x.r = r; x.clr = clr;
        x.exp_cnt = ec; x.exp_stk = es;
        return x;
    endfunction

    function automatic logic [31:0] stored_sum(logic [31:0] s, bit o);
`ifdef RESULT_SAT_EN
        if (o) return s[31] ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return s;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive inputs, check handshake and popped head, clock, check status
    task automatic step(vec_t x);
        bit push, pop;
        logic [33:0] e;
        valid_i = x.v; sum_i = x.s; carry_i = x.c; overflow_i = x.o;
        ready_i = x.r; clear_i = x.clr;
        #1;
        check("ready_o", ready_o, occ != 2);
        check("valid_o", valid_o, occ != 0);
        push = x.v && (occ != 2);
        pop  = x.r && (occ != 0);
        if (pop) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sum_o", sum_o, e[33:2]);
                check("carry_o", carry_o, e[1]);
                check("overflow_o", overflow_o, e[0]);
            end
        end
        if (push) begin
            sb.push_back({stored_sum(x.s, x.o), x.c, x.o});
            m_cnt = x.clr ? 1 : ((m_cnt + 1) & 32'hFFFF);
            m_stk = x.clr ? x.o : (m_stk | x.o);
        end else if (x.clr) begin
            m_cnt = 0;
            m_stk = 0;
        end
        occ = occ + (push ? 1 : 0) - (pop ? 1 : 0);
        @(posedge clk); #1;
        check("result_count_o", result_count_o, m_cnt);
        check("sticky_ovf_o", sticky_ovf_o, m_stk);
        if (x.exp_cnt >= 0) check("count_plan", result_count_o, x.exp_cnt);
        if (x.exp_stk >= 0) check("sticky_plan", sticky_ovf_o, x.exp_stk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_i = 1'b1; sum_i = 32'hDEAD_BEEF; carry_i = 1'b1; overflow_i = 1'b1;
        ready_i = 1'b1; clear_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        occ = 0; m_cnt = 0; m_stk = 0;
        check("rst_valid_o", valid_o, 0);
        check("rst_ready_o", ready_o, 1);
        check("rst_sum_o", sum_o, 0);
        check("rst_carry_o", carry_o, 0);
        check("rst_overflow_o", overflow_o, 0);
        check("rst_count", result_count_o, 0);
        check("rst_sticky", sticky_ovf_o, 0);
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; valid_i = 0; sum_i = 0; carry_i = 0; overflow_i = 0;
        ready_i = 0; clear_i = 0;
        occ = 0; m_cnt = 0; m_stk = 0;

        // Table: fields v, sum, carry, ovf, ready_i, clear, exp_cnt, exp_sticky
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 0,  0,  0));
        vecs.push_back(mk(1, 32'h0000_0005,  0, 0, 1, 0,  1,  0));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 0,  1, -1));
        // backpressure: two absorbed, third held until room
        vecs.push_back(mk(1, 32'h11,         0, 0, 0, 0, -1, -1));
        vecs.push_back(mk(1, 32'h22,         1, 0, 0, 0, -1, -1));
        vecs.push_back(mk(1, 32'h33,         0, 0, 0, 0,  3, -1));
        vecs.push_back(mk(1, 32'h33,         0, 0, 0, 0,  3, -1));
        vecs.push_back(mk(1, 32'h33,         0, 0, 1, 0,  3, -1));
        vecs.push_back(mk(1, 32'h33,         0, 0, 1, 0,  4, -1));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 0,  4,  0));
        // overflow and saturation in both directions
        vecs.push_back(mk(1, 32'h8000_0000,  1, 1, 1, 0,  5,  1));
        vecs.push_back(mk(1, 32'h7FFF_FFFE,  0, 1, 1, 0,  6,  1));
        vecs.push_back(mk(1, 32'hFFFF_FFFF,  1, 0, 1, 0,  7,  1));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 0, -1, -1));
        // clear with push of ovf=1, then clear alone
        vecs.push_back(mk(1, 32'h1234_5678,  0, 1, 1, 1,  1,  1));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 1,  0,  0));
        // clear with a non-overflow push drops sticky
        vecs.push_back(mk(1, 32'h0000_0001,  0, 1, 1, 0,  1,  1));
        vecs.push_back(mk(1, 32'h0000_0002,  0, 0, 1, 1,  1,  0));
        // sustained throughput
        vecs.push_back(mk(1, 32'hA0,         0, 0, 1, 0,  2, -1));
        vecs.push_back(mk(1, 32'hA1,         0, 0, 1, 0,  3, -1));
        vecs.push_back(mk(1, 32'hA2,         1, 0, 1, 0,  4, -1));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 0, -1, -1));
        vecs.push_back(mk(0, 32'h0,          0, 0, 1, 0, -1, -1));

        do_reset();
        foreach (vecs[i]) step(vecs[i]);

        // Head held stable while stalled
        step(mk(1, 32'h55, 0, 0, 0, 0, -1, -1));
        check("hold_sum_1", sum_o, 32'h55);
        step(mk(0, 32'h0, 0, 0, 0, 0, -1, -1));
        check("hold_sum_2", sum_o, 32'h55);
        step(mk(0, 32'h0, 0, 0, 1, 0, -1, -1));

        // Reset while FULL: buffered 0x11/0x22 must be discarded
        step(mk(1, 32'h11, 0, 0, 0, 0, -1, -1));
        step(mk(1, 32'h22, 0, 0, 0, 0, -1, -1));
        check("full_ready_o", ready_o, 0);
        do_reset();
        step(mk(0, 32'h0, 0, 0, 1, 0, 0, 0));
        step(mk(1, 32'h44, 0, 0, 1, 0, 1, 0));
        step(mk(0, 32'h0, 0, 0, 1, 0, 1, 0));

        // Random traffic against the scoreboard
        for (int k = 0; k < 200; k++) begin
            step(mk($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0, -1, -1));
        end
        for (int k = 0; k < 3; k++) step(mk(0, 32'h0, 0, 0, 1, 0, -1, -1));
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
